// File: rtl/video_pixel_fifo.sv
// video_pixel_fifo
// Pixel output stage behind video_timing. Decoded pixels arrive on a valid/ready
// handshake and wait in a small circular buffer. One pixel is popped per new_pixel
// strobe and driven out as registered RGB with a matching data-enable. Every
// new_frame flushes the buffer so each field starts aligned. Pops that find the
// buffer empty are counted in a saturating debug counter.
module video_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     new_pixel,
    input  logic                     new_frame,
    input  logic                     hblank,
    input  logic                     vblank,
    output logic [WIDTH-1:0]         out_rgb,
    output logic                     out_de,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               underflow_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             blank;
    logic             push;
    logic             pop;
    logic             underflow_hit;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // without a separate counter; level falls out of the pointer difference.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign blank = hblank || vblank;

    // A new_frame pulse takes priority over everything, so it blocks the
    // handshake, pops and underflow accounting in the same cycle. The full
    // check deliberately ignores a same-cycle pop.
    assign in_ready      = (state == RUN) && !full && !new_frame;
    assign push          = in_valid && in_ready;
    assign pop           = (state == RUN) && new_pixel && !new_frame && !empty;
    assign underflow_hit = (state == RUN) && new_pixel && !new_frame && empty;

    // Flush/run control: FLUSH always lasts exactly one cycle and clears both
    // pointers; RUN advances the pointers on accepted pushes and pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FLUSH;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case (state)
                FLUSH: begin
                    state  <= RUN;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end
                RUN: begin
                    if (new_frame) begin
                        state  <= FLUSH;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + (AW+1)'(1);
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + (AW+1)'(1);
                        end
                    end
                end
                default: begin
                    state  <= FLUSH;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end
            endcase
        end
    end

    // Pixel storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Registered outputs: blanking forces black, a pop presents the head, an
    // underflow shows black, otherwise the last pixel is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_rgb       <= '0;
            out_de        <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            out_de <= !blank;
            if (blank) begin
                out_rgb <= '0;
            end else if (pop) begin
                out_rgb <= mem[rd_ptr[AW-1:0]];
            end else if (underflow_hit) begin
                out_rgb <= '0;
            end
            if (underflow_hit && (underflow_cnt != 8'hFF)) begin
                underflow_cnt <= underflow_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_pixel_fifo.sv
// tb_video_pixel_fifo
// Self-checking bench for video_pixel_fifo. A queue-based reference model tracks
// the buffered pixels, the flush/run phase, the expected registered outputs and
// the underflow count; each scenario task drives cycles and compares inline.
module tb_video_pixel_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 24;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             new_pixel;
    logic             new_frame;
    logic             hblank;
    logic             vblank;
    logic [WIDTH-1:0] out_rgb;
    logic             out_de;
    logic [4:0]       level;
    logic [7:0]       underflow_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit               m_run;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rgb;
    logic             m_de;
    int               m_uf;
    logic             m_ready;
    logic             got_ready;

    video_pixel_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .new_pixel     (new_pixel),
        .new_frame     (new_frame),
        .hblank        (hblank),
        .vblank        (vblank),
        .out_rgb       (out_rgb),
        .out_de        (out_de),
        .level         (level),
        .underflow_cnt (underflow_cnt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; samples in_ready before the edge and advances the model after it
    task automatic tick(input logic iv, input logic [WIDTH-1:0] id, input logic np,
                        input logic nf, input logic hb, input logic vb);
        logic [WIDTH-1:0] head;
        bit do_pop, do_uf, do_push;
        in_valid  = iv;
        in_data   = id;
        new_pixel = np;
        new_frame = nf;
        hblank    = hb;
        vblank    = vb;
        #1;
        m_ready   = m_run && (q.size() < DEPTH) && !nf;
        got_ready = in_ready;
        @(posedge clk);
        #1;
        do_pop  = m_run && !nf && np && (q.size() > 0);
        do_uf   = m_run && !nf && np && (q.size() == 0);
        do_push = iv && m_ready;
        head = '0;
        if (do_pop) head = q.pop_front();
        if (do_push) q.push_back(id);
        if (!m_run || nf) q.delete();
        m_run = m_run ? !nf : 1'b1;
        if (do_uf && m_uf < 255) m_uf++;
        if (hb || vb) m_rgb = '0;
        else if (do_pop) m_rgb = head;
        else if (do_uf) m_rgb = '0;
        m_de = !(hb || vb);
    endtask

    // Hold reset for two edges and return the model to its reset state
    task automatic do_reset();
        reset = 1'b1;
        in_valid = 0; in_data = '0; new_pixel = 0; new_frame = 0; hblank = 0; vblank = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_run = 0; q.delete(); m_rgb = '0; m_de = 0; m_uf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (out_rgb !== '0) begin bad++; $display("[TB] FAIL reset_rgb got=%h exp=0", out_rgb); end
        total++; if (out_de !== 1'b0) begin bad++; $display("[TB] FAIL reset_de got=%b exp=0", out_de); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
        total++; if (underflow_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_uf got=%0d exp=0", underflow_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_basic();
        tick(0, '0, 0, 0, 0, 0);
        tick(1, 24'h112233, 0, 0, 0, 0);
        tick(1, 24'h445566, 0, 0, 0, 0);
        total++; if (level !== 5'd2) begin bad++; $display("[TB] FAIL basic_level2 got=%0d exp=2", level); end
        tick(0, '0, 1, 0, 0, 0);
        total++; if (out_rgb !== 24'h112233) begin bad++; $display("[TB] FAIL basic_first got=%h exp=112233", out_rgb); end
        tick(0, '0, 1, 0, 0, 0);
        total++; if (out_rgb !== 24'h445566) begin bad++; $display("[TB] FAIL basic_second got=%h exp=445566", out_rgb); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL basic_level0 got=%0d exp=0", level); end
        total++; if (out_de !== 1'b1) begin bad++; $display("[TB] FAIL basic_de got=%b exp=1", out_de); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) tick(1, WIDTH'($urandom), 0, 0, 0, 0);
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL full_level got=%0d exp=16", level); end
        tick(1, 24'hABCDEF, 0, 0, 0, 0);
        total++; if (got_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b exp=0", got_ready); end
        tick(1, 24'hABCDEF, 1, 0, 0, 0);
        total++; if (got_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready_on_pop got=%b exp=0", got_ready); end
        total++; if (level !== 5'd15) begin bad++; $display("[TB] FAIL full_level_after_pop got=%0d exp=15", level); end
        tick(1, 24'hABCDEF, 0, 0, 0, 0);
        total++; if (got_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready_after_pop got=%b exp=1", got_ready); end
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL full_level_refill got=%0d exp=16", level); end
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, '0, 1, 0, 0, 0);
            total++; if (out_rgb !== m_rgb) begin bad++; $display("[TB] FAIL full_drain_%0d got=%h exp=%h", i, out_rgb, m_rgb); end
        end
        total++; if (out_rgb !== 24'hABCDEF) begin bad++; $display("[TB] FAIL full_last got=%h exp=abcdef", out_rgb); end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            tick(0, '0, 1, 0, 0, 0);
            total++; if (out_rgb !== '0) begin bad++; $display("[TB] FAIL uf_rgb_%0d got=%h exp=0", i, out_rgb); end
        end
        total++; if (underflow_cnt !== 8'd3) begin bad++; $display("[TB] FAIL uf_count3 got=%0d exp=3", underflow_cnt); end
        for (int i = 0; i < 300; i++) tick(0, '0, 1, 0, 0, 0);
        total++; if (underflow_cnt !== 8'd255) begin bad++; $display("[TB] FAIL uf_saturate got=%0d exp=255", underflow_cnt); end
    endtask

    task automatic test_flush();
        int uf_before;
        for (int i = 0; i < 5; i++) tick(1, WIDTH'($urandom), 0, 0, 0, 0);
        total++; if (level !== 5'd5) begin bad++; $display("[TB] FAIL flush_level5 got=%0d exp=5", level); end
        uf_before = int'(underflow_cnt);
        tick(1, 24'h777777, 1, 1, 0, 0);
        total++; if (got_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready_nf got=%b exp=0", got_ready); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL flush_level0 got=%0d exp=0", level); end
        total++; if (int'(underflow_cnt) !== m_uf) begin bad++; $display("[TB] FAIL flush_uf got=%0d exp=%0d", underflow_cnt, m_uf); end
        tick(1, 24'h888888, 0, 0, 0, 0);
        total++; if (got_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready_state got=%b exp=0", got_ready); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL flush_no_push got=%0d exp=0", level); end
        tick(1, 24'h999999, 0, 0, 0, 0);
        total++; if (got_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready_run got=%b exp=1", got_ready); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL flush_push_run got=%0d exp=1", level); end
        total++; if (uf_before !== m_uf) begin bad++; $display("[TB] FAIL flush_uf_model got=%0d exp=%0d", uf_before, m_uf); end
    endtask

    task automatic test_blank();
        tick(1, 24'h0A0B0C, 0, 0, 0, 0);
        tick(0, '0, 1, 0, 0, 0);
        total++; if (out_rgb !== m_rgb) begin bad++; $display("[TB] FAIL blank_pre got=%h exp=%h", out_rgb, m_rgb); end
        tick(0, '0, 0, 0, 1, 0);
        total++; if (out_de !== 1'b0) begin bad++; $display("[TB] FAIL blank_de got=%b exp=0", out_de); end
        total++; if (out_rgb !== '0) begin bad++; $display("[TB] FAIL blank_rgb got=%h exp=0", out_rgb); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL blank_level got=%0d exp=1", level); end
        tick(0, '0, 0, 0, 0, 1);
        total++; if (out_de !== 1'b0) begin bad++; $display("[TB] FAIL vblank_de got=%b exp=0", out_de); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] old_head;
        logic [WIDTH-1:0] fresh;
        while (q.size() > 1) tick(0, '0, 1, 0, 0, 0);
        if (q.size() == 0) tick(1, WIDTH'($urandom), 0, 0, 0, 0);
        old_head = q[0];
        fresh = WIDTH'($urandom);
        tick(1, fresh, 1, 0, 0, 0);
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL b2b_level got=%0d exp=1", level); end
        total++; if (out_rgb !== old_head) begin bad++; $display("[TB] FAIL b2b_old got=%h exp=%h", out_rgb, old_head); end
        tick(0, '0, 1, 0, 0, 0);
        total++; if (out_rgb !== fresh) begin bad++; $display("[TB] FAIL b2b_new got=%h exp=%h", out_rgb, fresh); end
    endtask

    task automatic test_random();
        logic hb, vb, np, nf, iv;
        for (int i = 0; i < 600; i++) begin
            hb = ($urandom_range(0, 9) == 0);
            vb = ($urandom_range(0, 19) == 0);
            np = !hb && !vb && ($urandom_range(0, 1) == 1);
            nf = ($urandom_range(0, 49) == 0);
            iv = ($urandom_range(0, 9) < 6);
            tick(iv, WIDTH'($urandom), np, nf, hb, vb);
            total++; if (got_ready !== m_ready) begin bad++; $display("[TB] FAIL rnd_ready_%0d got=%b exp=%b", i, got_ready, m_ready); end
            total++; if (out_rgb !== m_rgb) begin bad++; $display("[TB] FAIL rnd_rgb_%0d got=%h exp=%h", i, out_rgb, m_rgb); end
            total++; if (out_de !== m_de) begin bad++; $display("[TB] FAIL rnd_de_%0d got=%b exp=%b", i, out_de, m_de); end
            total++; if (int'(level) !== q.size()) begin bad++; $display("[TB] FAIL rnd_level_%0d got=%0d exp=%0d", i, level, q.size()); end
            total++; if (int'(underflow_cnt) !== m_uf) begin bad++; $display("[TB] FAIL rnd_uf_%0d got=%0d exp=%0d", i, underflow_cnt, m_uf); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) tick(1, WIDTH'($urandom), 0, 0, 0, 0);
        tick(0, '0, 1, 0, 0, 0);
        do_reset();
        #1;
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL midreset_level got=%0d exp=0", level); end
        total++; if (out_rgb !== '0) begin bad++; $display("[TB] FAIL midreset_rgb got=%h exp=0", out_rgb); end
        total++; if (underflow_cnt !== 8'd0) begin bad++; $display("[TB] FAIL midreset_uf got=%0d exp=0", underflow_cnt); end
        tick(0, '0, 0, 0, 0, 0);
        tick(0, '0, 1, 0, 0, 0);
        total++; if (underflow_cnt !== 8'd1) begin bad++; $display("[TB] FAIL midreset_empty got=%0d exp=1", underflow_cnt); end
    endtask

    // Scenario sequence
    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = '0; new_pixel = 0; new_frame = 0; hblank = 0; vblank = 0;
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_flush();
        test_blank();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
